// File: rtl/regfile_writeback.sv
// Writeback arbiter: grants up to two of three producers onto regfile ports C/D with no same-register pair; latency 1 cycle.
// Backpressure: src_ready is combinational and low during freeze/reset; optional WB_PERF_CNT_EN adds collision/freeze counters.
module regfile_writeback #(
    parameter int LOG_REG_CNT = 2,
    parameter int LOG_THREADS = 2,
    parameter int REG_WIDTH   = 288,
    parameter int ADDR_W      = LOG_REG_CNT * (1 << LOG_THREADS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     freeze,
    input  logic [2:0]               src_valid,
    output logic [2:0]               src_ready,
    input  logic [3*LOG_THREADS-1:0] src_thread,
    input  logic [3*LOG_REG_CNT-1:0] src_reg,
    input  logic [3*REG_WIDTH-1:0]   src_data,
    output logic                     port_c_we,
    output logic                     port_d_we,
    output logic [ADDR_W-1:0]        port_c_write_addr,
    output logic [ADDR_W-1:0]        port_d_write_addr,
    output logic [REG_WIDTH-1:0]     port_c_in,
    output logic [REG_WIDTH-1:0]     port_d_in
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]              perf_collision_cnt,
    output logic [31:0]              perf_freeze_cnt
`endif
);

    function automatic logic [1:0] f_mod3_add(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    logic [1:0]           r_rr_ptr;
    logic                 r_c_we, r_d_we;
    logic [ADDR_W-1:0]    r_c_addr, r_d_addr;
    logic [REG_WIDTH-1:0] r_c_data, r_d_data;

    logic [ADDR_W-1:0]    w_addr [3];
    logic [REG_WIDTH-1:0] w_data [3];
    logic                 w_a_vld, w_b_cand, w_b_vld, w_collide, w_accept;
    logic [1:0]           w_a_idx, w_b_idx, w_scan_idx;

    assign w_accept = !freeze && !reset;

    for (genvar i = 0; i < 3; i++) begin : g_src
        assign w_addr[i] = ADDR_W'({src_thread[i*LOG_THREADS +: LOG_THREADS],
                                    src_reg[i*LOG_REG_CNT +: LOG_REG_CNT]});
        assign w_data[i] = src_data[i*REG_WIDTH +: REG_WIDTH];
        assign src_ready[i] = w_accept && ((w_a_vld && w_a_idx == 2'(i)) ||
                                           (w_b_vld && w_b_idx == 2'(i)));
    end

    // Only the second valid producer in scan order may pair with A; a
    // matching address defers it rather than skipping ahead to the third.
    always_comb begin
        w_a_vld    = 1'b0;
        w_a_idx    = 2'd0;
        w_b_cand   = 1'b0;
        w_b_idx    = 2'd0;
        w_scan_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            w_scan_idx = f_mod3_add(r_rr_ptr, 2'(k));
            if (src_valid[w_scan_idx]) begin
                if (!w_a_vld) begin
                    w_a_vld = 1'b1;
                    w_a_idx = w_scan_idx;
                end else if (!w_b_cand) begin
                    w_b_cand = 1'b1;
                    w_b_idx  = w_scan_idx;
                end
            end
        end
        w_collide = w_b_cand && (w_addr[w_b_idx] == w_addr[w_a_idx]);
        w_b_vld   = w_b_cand && !w_collide;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
            r_c_we   <= 1'b0;
            r_d_we   <= 1'b0;
            r_c_addr <= '0;
            r_d_addr <= '0;
            r_c_data <= '0;
            r_d_data <= '0;
        end else if (!freeze) begin
            r_c_we <= w_a_vld;
            r_d_we <= w_b_vld;
            if (w_a_vld) begin
                r_c_addr <= w_addr[w_a_idx];
                r_c_data <= w_data[w_a_idx];
                r_rr_ptr <= f_mod3_add(w_b_vld ? w_b_idx : w_a_idx, 2'd1);
            end
            if (w_b_vld) begin
                r_d_addr <= w_addr[w_b_idx];
                r_d_data <= w_data[w_b_idx];
            end
        end
    end

    assign port_c_we         = r_c_we;
    assign port_d_we         = r_d_we;
    assign port_c_write_addr = r_c_addr;
    assign port_d_write_addr = r_d_addr;
    assign port_c_in         = r_c_data;
    assign port_d_in         = r_d_data;

`ifdef WB_PERF_CNT_EN
    logic [31:0] r_coll_cnt, r_frz_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coll_cnt <= '0;
            r_frz_cnt  <= '0;
        end else begin
            if (!freeze && w_collide && r_coll_cnt != '1) r_coll_cnt <= r_coll_cnt + 32'd1;
            if (freeze && |src_valid && r_frz_cnt != '1) r_frz_cnt <= r_frz_cnt + 32'd1;
        end
    end

    assign perf_collision_cnt = r_coll_cnt;
    assign perf_freeze_cnt    = r_frz_cnt;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic against a scan-list reference model.
module tb_regfile_writeback;
    logic         clk = 1'b0;
    logic         reset, freeze;
    logic [2:0]   v;
    logic [1:0]   th [3];
    logic [1:0]   rg [3];
    logic [287:0] dt [3];

    logic [2:0]   src_valid, src_ready;
    logic [5:0]   src_thread, src_reg;
    logic [863:0] src_data;
    logic         port_c_we, port_d_we;
    logic [7:0]   port_c_write_addr, port_d_write_addr;
    logic [287:0] port_c_in, port_d_in;
`ifdef WB_PERF_CNT_EN
    logic [31:0]  perf_collision_cnt, perf_freeze_cnt;
`endif

    always_comb begin
        src_valid  = v;
        src_thread = {th[2], th[1], th[0]};
        src_reg    = {rg[2], rg[1], rg[0]};
        src_data   = {dt[2], dt[1], dt[0]};
    end

    regfile_writeback dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_thread(src_thread), .src_reg(src_reg), .src_data(src_data),
        .port_c_we(port_c_we), .port_d_we(port_d_we),
        .port_c_write_addr(port_c_write_addr), .port_d_write_addr(port_d_write_addr),
        .port_c_in(port_c_in), .port_d_in(port_d_in)
`ifdef WB_PERF_CNT_EN
        , .perf_collision_cnt(perf_collision_cnt), .perf_freeze_cnt(perf_freeze_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int           m_rr;
    logic         m_c_we, m_d_we;
    logic [7:0]   m_c_addr, m_d_addr;
    logic [287:0] m_c_data, m_d_data;
    logic [31:0]  m_cc, m_fc;
    logic [2:0]   exp_rdy;

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] faddr(input int i);
        return 8'(int'(th[i]) * 4 + int'(rg[i]));
    endfunction

    task automatic new_item(input int i);
        v[i]  = 1'b1;
        th[i] = 2'($urandom_range(0, 3));
        rg[i] = 2'($urandom_range(0, 1));
        dt[i] = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_item(input int i, input int t, input int r, input logic [287:0] d);
        v[i] = 1'b1; th[i] = 2'(t); rg[i] = 2'(r); dt[i] = d;
    endtask

    // One clock: predict grants from the ordered list of valid producers,
    // check ready, advance the model at the edge, check the registered ports.
    task automatic step(input bit rnd);
        int  q[$];
        int  ga, gb, last;
        bit  coll;
        q = {};
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_rr + k) % 3;
            if (v[idx]) q.push_back(idx);
        end
        ga = -1; gb = -1; coll = 0;
        if (q.size() > 0) ga = q[0];
        if (q.size() > 1) begin
            if (faddr(q[1]) != faddr(q[0])) gb = q[1];
            else coll = 1;
        end
        exp_rdy = 3'b000;
        if (!freeze && !reset) begin
            if (ga >= 0) exp_rdy[ga] = 1'b1;
            if (gb >= 0) exp_rdy[gb] = 1'b1;
        end
        #1 chk("src_ready", 288'(src_ready), 288'(exp_rdy));
        @(posedge clk);
        if (reset) begin
            m_rr = 0; m_c_we = 0; m_d_we = 0;
            m_c_addr = 0; m_d_addr = 0; m_c_data = 0; m_d_data = 0;
            m_cc = 0; m_fc = 0;
        end else begin
            if (freeze && |v && m_fc != 32'hFFFF_FFFF) m_fc++;
            if (!freeze) begin
                if (coll && m_cc != 32'hFFFF_FFFF) m_cc++;
                m_c_we = (ga >= 0);
                m_d_we = (gb >= 0);
                if (ga >= 0) begin m_c_addr = faddr(ga); m_c_data = dt[ga]; end
                if (gb >= 0) begin m_d_addr = faddr(gb); m_d_data = dt[gb]; end
                if (ga >= 0) begin
                    last = (gb >= 0) ? gb : ga;
                    m_rr = (last + 1) % 3;
                end
            end
        end
        #1;
        chk("c_we", 288'(port_c_we), 288'(m_c_we));
        chk("d_we", 288'(port_d_we), 288'(m_d_we));
        chk("rr_ptr", 288'(dut.r_rr_ptr), 288'(m_rr));
        if (m_c_we) begin
            chk("c_addr", 288'(port_c_write_addr), 288'(m_c_addr));
            chk("c_data", port_c_in, m_c_data);
        end
        if (m_d_we) begin
            chk("d_addr", 288'(port_d_write_addr), 288'(m_d_addr));
            chk("d_data", port_d_in, m_d_data);
        end
`ifdef WB_PERF_CNT_EN
        chk("perf_coll", 288'(perf_collision_cnt), 288'(m_cc));
        chk("perf_frz", 288'(perf_freeze_cnt), 288'(m_fc));
`endif
        for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i]) begin
                if (rnd && $urandom_range(0, 3) != 0) new_item(i);
                else v[i] = 1'b0;
            end else if (rnd && !v[i] && $urandom_range(0, 1) == 1) begin
                new_item(i);
            end
        end
        if (rnd) begin
            freeze = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 59) == 0);
        end
    endtask

    initial begin
        reset = 1'b1; freeze = 1'b0; v = 3'b000;
        for (int i = 0; i < 3; i++) begin th[i] = 0; rg[i] = 0; dt[i] = '0; end
        m_rr = 0; m_c_we = 0; m_d_we = 0; m_c_addr = 0; m_d_addr = 0;
        m_c_data = 0; m_d_data = 0; m_cc = 0; m_fc = 0; exp_rdy = 0;

        step(0); step(0);
        chk("rst_c_addr", 288'(port_c_write_addr), 288'd0);
        chk("rst_c_data", port_c_in, 288'd0);
        reset = 1'b0;

        set_item(1, 2, 3, 288'hA5);
        step(0);
        chk("single_c_we", 288'(port_c_we), 288'd1);
        chk("single_addr", 288'(port_c_write_addr), 288'd11);
        chk("single_data", port_c_in, 288'hA5);
        chk("single_d_we", 288'(port_d_we), 288'd0);

        reset = 1'b1; step(0); reset = 1'b0;
        set_item(0, 0, 0, 288'h100);
        set_item(1, 1, 2, 288'h200);
        set_item(2, 3, 3, 288'h300);
        step(0);
        chk("three_c_addr", 288'(port_c_write_addr), 288'd0);
        chk("three_d_addr", 288'(port_d_write_addr), 288'd6);
        chk("three_rr", 288'(dut.r_rr_ptr), 288'd2);
        step(0);
        chk("three2_c_addr", 288'(port_c_write_addr), 288'd15);
        chk("three2_d_we", 288'(port_d_we), 288'd0);
        chk("three2_rr", 288'(dut.r_rr_ptr), 288'd0);

        set_item(0, 0, 1, 288'h11);
        set_item(1, 0, 1, 288'h22);
        step(0);
        chk("coll_c_data", port_c_in, 288'h11);
        chk("coll_d_we", 288'(port_d_we), 288'd0);
        step(0);
        chk("coll2_c_addr", 288'(port_c_write_addr), 288'd1);
        chk("coll2_c_data", port_c_in, 288'h22);

        set_item(0, 1, 1, 288'h55);
        step(0);
        set_item(2, 2, 0, 288'h77);
        freeze = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(0);
            chk("frz_c_we", 288'(port_c_we), 288'd1);
            chk("frz_c_addr", 288'(port_c_write_addr), 288'd5);
            chk("frz_ready", 288'(src_ready), 288'd0);
        end
        freeze = 1'b0;
        step(0);
        chk("unfrz_c_addr", 288'(port_c_write_addr), 288'd8);

        set_item(0, 3, 1, 288'h99);
        step(0);
        chk("mid_c_we", 288'(port_c_we), 288'd1);
        reset = 1'b1;
        step(0);
        chk("mid_rst_c_we", 288'(port_c_we), 288'd0);
        chk("mid_rst_d_we", 288'(port_d_we), 288'd0);
        chk("mid_rst_rr", 288'(dut.r_rr_ptr), 288'd0);
`ifdef WB_PERF_CNT_EN
        chk("mid_rst_perf", 288'({perf_collision_cnt, perf_freeze_cnt}), 288'd0);
`endif
        reset = 1'b0;

        for (int n = 0; n < 3000; n++) step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback arbiter directly upstream of the register file's two write ports (C and D).
- Collects results from three producers: 0 = ALU, 1 = matmul unit, 2 = load unit. Each producer uses a valid/ready handshake.
- Grants up to two results per cycle and drives registered we/addr/data onto ports C and D.
- Guarantees that C and D never target the same register in one cycle, and honours the pipeline-wide freeze.

Parameters:
- LOG_REG_CNT, 2, log2 of registers per thread.
- LOG_THREADS, 2, log2 of thread count (SUPERSCALAR_WIDTH = 1<<LOG_THREADS = 4).
- REG_WIDTH, 288, data width (4x4 matrix of 18-bit elements).
- ADDR_W, LOG_REG_CNT*(1<<LOG_THREADS) = 8, width of the regfile address ports driven by this block.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- freeze  in  1  pipeline freeze; same signal the regfile receives
- src_valid  in  3  per-producer result valid
- src_ready  out  3  per-producer accept; combinational
- src_thread  in  3*LOG_THREADS  per-producer thread id, packed, producer 0 in the LSBs
- src_reg  in  3*LOG_REG_CNT  per-producer register index, packed
- src_data  in  3*REG_WIDTH  per-producer result, packed
- port_c_we, port_d_we  out  1 each  write enables to the regfile
- port_c_write_addr, port_d_write_addr  out  ADDR_W each  flat address = thread*(1<<LOG_REG_CNT)+reg, zero-extended
- port_c_in, port_d_in  out  REG_WIDTH each  write data

Behaviour:
- Reset:
  - port_c_we = port_d_we = 0.
  - Addresses and data = 0.
  - rr_ptr = 0.
  - src_ready = 0 during the reset cycle.
- Handshake:
  - A result transfers when src_valid[i] && src_ready[i] at a rising edge.
  - The producer holds thread/reg/data stable while valid && !ready.
- Arbitration, combinational each cycle:
  - Scan producers in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first valid producer is grant A, routed to port C.
  - The next valid producer is grant B, routed to port D, but only if its flat address differs from grant A's.
  - If B's address equals A's, B is deferred (ready=0) and retries next cycle.
- src_ready[i] = !freeze && !reset && (i is grant A or grant B).
- rr_ptr update:
  - If at least one grant: rr_ptr <= (last granted index + 1) mod 3.
  - If no grant: rr_ptr unchanged.
  - rr_ptr never reaches 3. On wrap from 2, rr_ptr = 0.
- Output register:
  - When !freeze: port_c_* <= grant A, port_d_* <= grant B, with we=0 for an absent grant.
  - Latency: a handshake at edge N produces we=1 in the cycle after edge N; the regfile commits at edge N+1.
- Freeze:
  - All outputs hold their value (we included). rr_ptr holds. src_ready = 0.
  - Held writes are committed by the regfile on the first unfrozen edge. There is no loss and no duplicate write.
- Ordering:
  - Results to the same address from different producers commit in handshake order.
  - The same-cycle collision rule means a deferred result always commits strictly later.
- Reset mid-operation: any result handshaked in the previous cycle but still in the output register is discarded; we=0 after reset.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- With the macro:
  - Adds outputs perf_collision_cnt (32) and perf_freeze_cnt (32).
  - perf_collision_cnt increments on every cycle where a B candidate is deferred due to an address match.
  - perf_freeze_cnt increments on every cycle with freeze=1 while any src_valid=1.
  - Both are cleared by reset and saturate at 0xFFFFFFFF.
- Without the macro: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single producer: only src 1 valid, thread 2, reg 3, data 0xA5 -> src_ready=010 that cycle; next cycle port_c_we=1, addr=11, data 0xA5, port_d_we=0.
- Three valid, rr_ptr=0, distinct addrs -> grants src 0 (C) and src 1 (D), rr_ptr becomes 2. Next cycle src 2 is granted on C, then rr_ptr=0.
- Collision: src 0 and src 1 both target thread 0 reg 1 -> only src 0 written (addr 1); src 1 is written one cycle later on port C.
- Freeze: assert freeze for 3 cycles right after a grant to addr 5 -> port_c_we=1 with addr 5 held for all 3 cycles, src_ready=000, rr_ptr unchanged; after release, exactly one write occurs before new grants.
- Reset mid-stream: assert reset while port_c_we=1 -> next cycle both we=0, rr_ptr=0, src_ready=000 during reset.
- WB_PERF_CNT_EN: 4 collision cycles and 2 freeze-with-valid cycles -> perf_collision_cnt=4, perf_freeze_cnt=2; both read 0 after reset.
